// File: rtl/seg7_pkg.sv
// Shared glyph codes and the active-low segment table (bit order gfedcba, bit 0 = segment a).
package seg7_pkg;

    localparam logic [4:0] CODE_OFF  = 5'h10;
    localparam logic [4:0] CODE_DASH = 5'h19;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    // 0x00-0x0F hex digits, 0x10 blank, then H h o L P t u y - a deg c n e r
    localparam logic [6:0] SEG_TABLE [0:31] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
        7'h7F, 7'h09, 7'h0B, 7'h23, 7'h47, 7'h0C, 7'h07, 7'h63,
        7'h11, 7'h3F, 7'h20, 7'h1C, 7'h27, 7'h2B, 7'h04, 7'h2F
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph-code to active-low segment pattern lookup.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [4:0] iCode,
    output logic [6:0] oSeg
);

    assign oSeg = SEG_TABLE[iCode];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: digit register file, prescaled scan with an
// anti-ghost gap, leading-zero suppression, blink, and a registered static bus.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 50000,
    parameter int BLINK_DIV  = 64,
    localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iWR,
    input  logic [AW-1:0]             iADDR,
    input  logic [4:0]                iWDATA,
    input  logic                      iLZS,
    input  logic [NUM_DIGITS-1:0]     iBLINK,
    output logic [6:0]                oSEG,
    output logic [NUM_DIGITS-1:0]     oDIG_SEL,
    output logic [7*NUM_DIGITS-1:0]   oSEG_ALL
);

    localparam int PW = $clog2(PRESCALE);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [4:0]              digitReg [NUM_DIGITS];
    logic [PW-1:0]           prescaleCnt;
    logic [AW-1:0]           scanIdx;
    logic [AW-1:0]           nextIdx;
    logic [BW-1:0]           wrapCnt;
    logic                    blinkPhase;
    logic                    scanActive;
    logic [4:0]              scanCode;
    logic [4:0]              nextCode;
    logic                    tick;
    logic                    wrap;
    logic                    zeroRun;
    logic [NUM_DIGITS-1:0]   blankMask;
    logic                    scanBlank;
    logic [6:0]              scanSeg;
    logic [NUM_DIGITS-1:0]   digSel;
    logic [7*NUM_DIGITS-1:0] segAllNext;
    logic [7*NUM_DIGITS-1:0] segAllReg;

    assign tick    = (prescaleCnt == PW'(PRESCALE - 1));
    assign wrap    = tick && (scanIdx == AW'(NUM_DIGITS - 1));
    assign nextIdx = wrap ? '0 : scanIdx + AW'(1);

    // Out-of-range addresses match no digit, so they are dropped here.
    always_ff @(posedge iCLK) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (iRST) begin
                digitReg[i] <= CODE_OFF;
            end else if (iWR && (iADDR == AW'(i))) begin
                digitReg[i] <= iWDATA;
            end
        end
    end

    always_comb begin
        nextCode = CODE_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (nextIdx == AW'(i)) begin
                nextCode = digitReg[i];
            end
        end
    end

    // The scanned code is captured on the tick, before any same-cycle write lands.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            prescaleCnt <= '0;
            scanIdx     <= '0;
            wrapCnt     <= '0;
            blinkPhase  <= 1'b0;
            scanActive  <= 1'b0;
            scanCode    <= CODE_OFF;
        end else begin
            prescaleCnt <= tick ? '0 : prescaleCnt + PW'(1);
            if (tick) begin
                scanIdx    <= nextIdx;
                scanCode   <= nextCode;
                scanActive <= 1'b1;
                if (wrap) begin
                    if (wrapCnt == BW'(BLINK_DIV - 1)) begin
                        wrapCnt    <= '0;
                        blinkPhase <= ~blinkPhase;
                    end else begin
                        wrapCnt <= wrapCnt + BW'(1);
                    end
                end
            end
        end
    end

    // Zero run is tracked from the most significant digit down; digit 0 always shows.
    always_comb begin
        blankMask = '0;
        zeroRun   = iLZS;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeroRun      = zeroRun && (digitReg[i] == 5'h00);
            blankMask[i] = ((i != 0) && zeroRun) || (blinkPhase && iBLINK[i]);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDigit
        logic [6:0] pat;
        seg7_decode uDecode (
            .iCode (blankMask[g] ? CODE_OFF : digitReg[g]),
            .oSeg  (pat)
        );
        assign segAllNext[7*g +: 7] = pat;
    end

    always_comb begin
        scanBlank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scanIdx == AW'(i)) begin
                scanBlank = blankMask[i];
            end
        end
    end

    seg7_decode uScanDecode (
        .iCode (scanBlank ? CODE_OFF : scanCode),
        .oSeg  (scanSeg)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            segAllReg <= '1;
        end else begin
            segAllReg <= segAllNext;
        end
    end

    // Selects stay dark until the first tick, and for the whole tick cycle.
    always_comb begin
        digSel = '1;
        if (!iRST && scanActive && !tick) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (scanIdx == AW'(i)) begin
                    digSel[i] = 1'b0;
                end
            end
        end
    end

    assign oDIG_SEL = digSel;
    assign oSEG     = (iRST || !scanActive) ? SEG_OFF : scanSeg;
    assign oSEG_ALL = iRST ? '1 : segAllReg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random traffic against a
// slot-arithmetic reference model.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int BD = 2;
    localparam int N3 = 3;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        wr    = 1'b0;
    logic        lzs   = 1'b0;
    logic [1:0]  addr  = '0;
    logic [4:0]  wdata = '0;
    logic [3:0]  blink = '0;

    logic [6:0]  seg;
    logic [3:0]  digSel;
    logic [27:0] segAll;
    logic [6:0]  seg3;
    logic [2:0]  digSel3;
    logic [20:0] segAll3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BLINK_DIV(BD)) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iWR      (wr),
        .iADDR    (addr),
        .iWDATA   (wdata),
        .iLZS     (lzs),
        .iBLINK   (blink),
        .oSEG     (seg),
        .oDIG_SEL (digSel),
        .oSEG_ALL (segAll)
    );

    seg7_scan_driver #(.NUM_DIGITS(N3), .PRESCALE(P), .BLINK_DIV(BD)) dut3 (
        .iCLK     (clk),
        .iRST     (rst),
        .iWR      (wr),
        .iADDR    (addr),
        .iWDATA   (wdata),
        .iLZS     (1'b0),
        .iBLINK   (3'b000),
        .oSEG     (seg3),
        .oDIG_SEL (digSel3),
        .oSEG_ALL (segAll3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [4:0] code);
        case (code)
            5'h00: return 7'h40;  5'h01: return 7'h79;  5'h02: return 7'h24;  5'h03: return 7'h30;
            5'h04: return 7'h19;  5'h05: return 7'h12;  5'h06: return 7'h02;  5'h07: return 7'h78;
            5'h08: return 7'h00;  5'h09: return 7'h10;  5'h0A: return 7'h08;  5'h0B: return 7'h03;
            5'h0C: return 7'h46;  5'h0D: return 7'h21;  5'h0E: return 7'h06;  5'h0F: return 7'h0E;
            5'h11: return 7'h09;  5'h12: return 7'h0B;  5'h13: return 7'h23;  5'h14: return 7'h47;
            5'h15: return 7'h0C;  5'h16: return 7'h07;  5'h17: return 7'h63;  5'h18: return 7'h11;
            5'h19: return 7'h3F;  5'h1A: return 7'h20;  5'h1B: return 7'h1C;  5'h1C: return 7'h27;
            5'h1D: return 7'h2B;  5'h1E: return 7'h04;  5'h1F: return 7'h2F;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference model: cyc counts clock edges since reset; every P-th cycle is a tick.
    logic [4:0]  mRegs  [N];
    logic [4:0]  mRegs3 [N3];
    logic [4:0]  mShown = 5'h10;
    int          cyc    = 0;
    logic [27:0] expQ[$];
    logic [20:0] expQ3[$];

    function automatic bit modelPhase();
        return (((cyc / P) / N) / BD) % 2 == 1;
    endfunction

    function automatic bit modelBlank(input int i);
        bit allZero;
        allZero = 1'b1;
        if (lzs && i != 0) begin
            for (int j = i; j < N; j++) begin
                if (mRegs[j] != 5'h00) allZero = 1'b0;
            end
            if (allZero) return 1'b1;
        end
        return modelPhase() && blink[i];
    endfunction

    function automatic logic [27:0] modelSegAll();
        logic [27:0] r;
        for (int i = 0; i < N; i++) begin
            r[7*i +: 7] = modelBlank(i) ? 7'h7F : glyph(mRegs[i]);
        end
        return r;
    endfunction

    function automatic logic [20:0] modelSegAll3();
        logic [20:0] r;
        for (int i = 0; i < N3; i++) begin
            r[7*i +: 7] = glyph(mRegs3[i]);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cyc    = 0;
            mShown = 5'h10;
            for (int i = 0; i < N; i++) mRegs[i] = 5'h10;
            for (int i = 0; i < N3; i++) mRegs3[i] = 5'h10;
            expQ.push_back(28'hFFFFFFF);
            expQ3.push_back(21'h1FFFFF);
        end else begin
            if (cyc % P == P - 1) mShown = mRegs[((cyc / P) + 1) % N];
            expQ.push_back(modelSegAll());
            expQ3.push_back(modelSegAll3());
            if (wr) begin
                mRegs[addr] = wdata;
                if (int'(addr) < N3) mRegs3[addr] = wdata;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic [27:0] e;
        logic [20:0] e3;
        logic [3:0]  expSel;
        int          idx;
        if (expQ.size() > 0) begin
            e  = expQ.pop_front();
            e3 = expQ3.pop_front();
            check("segAll", segAll, rst ? 28'hFFFFFFF : e);
            check("segAll3", segAll3, rst ? 21'h1FFFFF : e3);
            if (rst || cyc < P) begin
                check("idleSel", digSel, 4'hF);
                check("idleSeg", seg, 7'h7F);
            end else if (cyc % P == P - 1) begin
                check("gapSel", digSel, 4'hF);
            end else begin
                idx    = (cyc / P) % N;
                expSel = 4'b0001 << idx;
                expSel = ~expSel;
                check("scanSel", digSel, expSel);
                check("scanSeg", seg, modelBlank(idx) ? 7'h7F : glyph(mShown));
            end
        end
    end

    task automatic doWrite(input logic [1:0] a, input logic [4:0] d);
        @(posedge clk); #1;
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk); #1;
        wr    = 1'b0;
    endtask

    initial begin
        int nIdx;
        bit found;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("rstSeg", seg, 7'h7F);
                check("rstSel", digSel, 4'hF);
                check("rstSegAll", segAll, 28'hFFFFFFF);
            end
            if (k == 3) check("firstGap", digSel, 4'hF);
            if (k == 4) check("firstSel", digSel, 4'b1101);
        end

        doWrite(2'd0, 5'h01);
        doWrite(2'd1, 5'h02);
        doWrite(2'd2, 5'h03);
        doWrite(2'd3, 5'h04);
        @(posedge clk);
        @(negedge clk);
        check("wr1234", segAll, {7'h19, 7'h30, 7'h24, 7'h79});
        check("oorIgnored", segAll3, {7'h30, 7'h24, 7'h79});
        repeat (2 * N * P) @(negedge clk);

        lzs = 1'b1;
        doWrite(2'd3, 5'h00);
        doWrite(2'd2, 5'h00);
        doWrite(2'd1, 5'h05);
        doWrite(2'd0, 5'h00);
        @(posedge clk);
        @(negedge clk);
        check("lzsMixed", segAll, {7'h7F, 7'h7F, 7'h12, 7'h40});
        repeat (N * P) @(negedge clk);
        doWrite(2'd1, 5'h00);
        @(posedge clk);
        @(negedge clk);
        check("lzsAllZero", segAll, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        repeat (N * P) @(negedge clk);

        lzs = 1'b0;
        for (int i = 0; i < N; i++) doWrite(2'(i), 5'h08);
        found = 1'b0;
        for (int k = 0; k < P + 2 && !found; k++) begin
            @(posedge clk); #1;
            if (cyc % P == P - 1) found = 1'b1;
        end
        check("tickFound", found, 1'b1);
        nIdx  = ((cyc / P) + 1) % N;
        wr    = 1'b1;
        addr  = 2'(nIdx);
        wdata = 5'h0A;
        @(posedge clk); #1;
        wr = 1'b0;
        @(negedge clk);
        check("collideOld", seg, 7'h00);
        repeat (N * P) @(negedge clk);
        check("collideNew", seg, 7'h08);

        blink = 4'b0001;
        repeat (12 * N * P) @(negedge clk);

        for (int n = 0; n < 900; n++) begin
            @(posedge clk); #1;
            wr    = ($urandom_range(0, 2) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = ($urandom_range(0, 2) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 30) == 0) lzs = ~lzs;
            if ($urandom_range(0, 60) == 0) blink = 4'($urandom_range(0, 15));
            rst   = ($urandom_range(0, 250) == 0);
        end
        @(posedge clk); #1;
        wr  = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
